// File: rtl/cpu_ram_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the shared RAM.
// The arbiter takes the slave view; the environment driving it takes master.
interface cpu_ram_arbiter_if #(
    parameter int ADDR_BITS = 14
);
    logic                 cpu_req;
    logic [3:0]           cpu_wstrb;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [31:0]          cpu_wdata;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;

    logic                 dma_req;
    logic                 dma_we;
    logic [ADDR_BITS-1:0] dma_addr;
    logic [31:0]          dma_wdata;
    logic                 dma_ready;
    logic [31:0]          dma_rdata;

    logic                 ram_cs;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [31:0]          ram_wdata;
    logic [3:0]           ram_wstrb;
    logic [31:0]          ram_rdata;

    modport slave (
        input  cpu_req, cpu_wstrb, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_ready, cpu_rdata,
        output dma_ready, dma_rdata,
        output ram_cs, ram_addr, ram_wdata, ram_wstrb
    );

    modport master (
        output cpu_req, cpu_wstrb, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_ready, cpu_rdata,
        input  dma_ready, dma_rdata,
        input  ram_cs, ram_addr, ram_wdata, ram_wstrb
    );
endinterface

// File: rtl/cpu_ram_arbiter.sv
// Two-master arbiter for a single-port synchronous CPU RAM.
// CPU has priority; a starvation counter eventually forces a DMA grant.
module cpu_ram_arbiter #(
    parameter int ADDR_BITS    = 14,
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    cpu_ram_arbiter_if.slave bus
);
    localparam int WW = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(DMA_MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_RESP,
        DMA_ACC,
        DMA_RESP
    } state_t;

    state_t               state;
    logic [WW-1:0]        wait_cnt;
    logic [WW-1:0]        wait_inc;
    logic                 dma_first;

    logic                 cs_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 cpu_rdy_q;
    logic                 dma_rdy_q;

    always_comb begin
        wait_inc  = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
        dma_first = bus.dma_req
                  && (!bus.cpu_req || wait_cnt == WAIT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cs_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            cpu_rdy_q <= 1'b0;
            dma_rdy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dma_first) begin
                        state    <= DMA_ACC;
                        cs_q     <= 1'b1;
                        addr_q   <= bus.dma_addr;
                        wdata_q  <= bus.dma_wdata;
                        wstrb_q  <= bus.dma_we ? 4'hF : 4'h0;
                        wait_cnt <= '0;
                    end else if (bus.cpu_req) begin
                        state    <= CPU_ACC;
                        cs_q     <= 1'b1;
                        addr_q   <= bus.cpu_addr;
                        wdata_q  <= bus.cpu_wdata;
                        wstrb_q  <= bus.cpu_wstrb;
                        wait_cnt <= bus.dma_req ? wait_inc : '0;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                CPU_ACC: begin
                    state     <= CPU_RESP;
                    cs_q      <= 1'b0;
                    wstrb_q   <= 4'h0;
                    cpu_rdy_q <= 1'b1;
                    wait_cnt  <= bus.dma_req ? wait_inc : '0;
                end
                CPU_RESP: begin
                    state     <= IDLE;
                    cpu_rdy_q <= 1'b0;
                    wait_cnt  <= bus.dma_req ? wait_inc : '0;
                end
                DMA_ACC: begin
                    state     <= DMA_RESP;
                    cs_q      <= 1'b0;
                    wstrb_q   <= 4'h0;
                    dma_rdy_q <= 1'b1;
                    if (!bus.dma_req) wait_cnt <= '0;
                end
                DMA_RESP: begin
                    state     <= IDLE;
                    dma_rdy_q <= 1'b0;
                    if (!bus.dma_req) wait_cnt <= '0;
                end
                default: begin
                    state     <= IDLE;
                    cs_q      <= 1'b0;
                    wstrb_q   <= 4'h0;
                    cpu_rdy_q <= 1'b0;
                    dma_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM data lands in the RESP cycle, so read data is passed straight through
    assign bus.ram_cs    = cs_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wstrb = wstrb_q;
    assign bus.cpu_ready = cpu_rdy_q;
    assign bus.dma_ready = dma_rdy_q;
    assign bus.cpu_rdata = cpu_rdy_q ? bus.ram_rdata : 32'h0;
    assign bus.dma_rdata = dma_rdy_q ? bus.ram_rdata : 32'h0;
endmodule

// File: doc/cpu_ram_arbiter.md
CPU_RAM_ARBITER -- requirements
Module: cpu_ram_arbiter

Interface
- REQ-001: Parameter ADDR_BITS, default 14: word-address width of the shared CPU RAM.
- REQ-002: Parameter DMA_MAX_WAIT, default 8: number of blocked DMA-wait cycles after which DMA takes priority.
- REQ-003: clk  in  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: cpu_req  in  1  CPU access request; held high until cpu_ready is seen.
- REQ-006: cpu_wstrb  in  4  byte write strobes; 0 = read.
- REQ-007: cpu_addr  in  ADDR_BITS  CPU word address.
- REQ-008: cpu_wdata  in  32  CPU write data.
- REQ-009: cpu_ready  out  1  one-cycle completion pulse to CPU.
- REQ-010: cpu_rdata  out  32  CPU read data; valid only while cpu_ready=1.
- REQ-011: dma_req  in  1  DMA request; held high until dma_ready is seen.
- REQ-012: dma_we  in  1  DMA full-word write enable.
- REQ-013: dma_addr  in  ADDR_BITS  DMA word address.
- REQ-014: dma_wdata  in  32  DMA write data.
- REQ-015: dma_ready  out  1  one-cycle completion pulse to DMA.
- REQ-016: dma_rdata  out  32  DMA read data; valid only while dma_ready=1.
- REQ-017: ram_cs  out  1  RAM select; ram_addr out ADDR_BITS; ram_wdata out 32; ram_wstrb out 4.
- REQ-018: ram_rdata  in  32  synchronous single-port RAM read data, valid the cycle after ram_cs=1.

Function
- REQ-019: FSM states SHALL be IDLE, CPU_ACC, CPU_RESP, DMA_ACC, DMA_RESP.
- REQ-020: In IDLE, the arbiter SHALL grant CPU if cpu_req=1, else DMA if dma_req=1, else remain in IDLE; exception: if wait_cnt==DMA_MAX_WAIT and dma_req=1, DMA SHALL be granted even when cpu_req=1.
- REQ-021: On grant, the granted requester's address, data and strobes SHALL be registered onto ram_addr/ram_wdata/ram_wstrb with ram_cs=1 during the ACC state (DMA: ram_wstrb = dma_we ? 4'hF : 4'h0).
- REQ-022: ACC SHALL last exactly one cycle and proceed to the matching RESP state; ram_cs SHALL be 0 in every state except ACC.
- REQ-023: In RESP, the matching ready output SHALL be 1 for exactly one cycle, its rdata output SHALL equal ram_rdata, and the FSM SHALL return to IDLE.
- REQ-024: Latency: ready SHALL assert 2 cycles after the edge at which the request was granted in IDLE; minimum spacing between grants is 3 cycles.
- REQ-025: cpu_ready and dma_ready SHALL never be 1 in the same cycle; at most one ACC is active at any time.
- REQ-026: wait_cnt (internal, saturating at DMA_MAX_WAIT) SHALL increment in each IDLE cycle where dma_req=1 and CPU is granted, and whenever dma_req=1 in a CPU_ACC/CPU_RESP cycle; it SHALL clear on DMA grant or when dma_req=0.
- REQ-027: A request withdrawn before grant SHALL cause no RAM access; a request changing after grant SHALL NOT affect the registered RAM outputs.
- REQ-028: Writes SHALL return ready with rdata don't-care; ready timing SHALL be identical for reads and writes.

Reset
- REQ-029: reset=1 SHALL immediately force IDLE, wait_cnt=0, ram_cs=0, ram_wstrb=0, ram_addr=0, ram_wdata=0, cpu_ready=0, dma_ready=0, irrespective of clk.
- REQ-030: Reset asserted during ACC or RESP SHALL abort the access with no ready pulse; after deassertion, arbitration SHALL restart from IDLE on the first clk edge.

Verification
- REQ-031: CPU read addr 0x0010, RAM holds 0xDEADBEEF -> ram_cs=1 one cycle, cpu_ready pulse 2 cycles after grant, cpu_rdata=0xDEADBEEF.
- REQ-032: CPU write wstrb=4'b0011 data 0x12345678 -> ram_wstrb=4'b0011 during ACC only, cpu_ready one pulse, dma_ready stays 0.
- REQ-033: cpu_req and dma_req both asserted, wait_cnt=0 -> CPU served first, then DMA granted in the next IDLE cycle.
- REQ-034: cpu_req held continuously back-to-back with dma_req high -> DMA granted once wait_cnt reaches 8; wait_cnt returns to 0.
- REQ-035: reset asserted mid DMA_ACC -> ram_cs drops at once, no dma_ready pulse; after release, a pending cpu_req is granted on the first edge.
- REQ-036: dma_req pulsed for one cycle while CPU is in CPU_ACC -> no DMA RAM access and no dma_ready.
